// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode and FSM encodings, widths.
package alu_pkg;

    localparam int DW    = 16;
    localparam int NREG  = 4;
    localparam int RW    = $clog2(NREG);
    localparam int REP_W = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_NAND = 4'h4,
        OP_NOR  = 4'h5,
        OP_XOR  = 4'h6,
        OP_XNOR = 4'h7,
        OP_ID   = 4'h8,
        OP_NOT  = 4'h9,
        OP_LRS  = 4'hA,
        OP_ARS  = 4'hB,
        OP_RR   = 4'hC,
        OP_LLS  = 4'hD,
        OP_ALS  = 4'hE,
        OP_RL   = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signals of the sequencer; slave = sequencer view.
interface alu_cmd_sequencer_if;
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [RW-1:0]    cmd_rd;
    logic [RW-1:0]    cmd_rs1;
    logic [RW-1:0]    cmd_rs2;
    logic             cmd_imm_en;
    logic [DW-1:0]    cmd_imm;
    logic [REP_W-1:0] cmd_rep;

    logic [DW-1:0]    alu_a;
    logic [DW-1:0]    alu_b;
    logic [3:0]       alu_op;
    logic [DW-1:0]    alu_c;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic             rsp_cout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_rep,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_c, alu_cout,
        output rsp_valid, rsp_data, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_rep,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_c, alu_cout,
        input  rsp_valid, rsp_data, rsp_cout,
        output rsp_ready
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port.
module alu_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the 16-bit ALU: runs each command rep+1 times with A feedback.
//  state   | meaning
//  IDLE    | cmd_ready high, waiting for a command
//  EXEC    | operands on ALU, one iteration per cycle until count reaches 0
//  RESP    | result held on rsp_* until rsp_ready
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_cmd_sequencer_if.slave bus
);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic             w_accept;
    logic             w_done;
    logic             w_rsp_hs;

    logic [DW-1:0]    r_opa;
    logic [DW-1:0]    r_opb;
    alu_op_e          r_op;
    logic [REP_W-1:0] r_count;
    logic [RW-1:0]    r_rd;
    logic [DW-1:0]    r_rsp_data;
    logic             r_rsp_cout;

    logic [DW-1:0]    w_rdata_a;
    logic [DW-1:0]    w_rdata_b;

    alu_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (RW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_done),
        .i_waddr   (r_rd),
        .i_wdata   (bus.alu_c),
        .i_raddr_a (bus.cmd_rs1),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (bus.cmd_rs2),
        .o_rdata_b (w_rdata_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_rsp_hs = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_count == '0) begin
                    w_done = 1'b1;
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_hs = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Sources are read at accept, so a write-back to rs1/rs2 never disturbs the running command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_op       <= OP_ID;
            r_count    <= '0;
            r_rd       <= '0;
            r_rsp_data <= '0;
            r_rsp_cout <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= w_rdata_a;
            r_opb   <= bus.cmd_imm_en ? bus.cmd_imm : w_rdata_b;
            r_op    <= alu_op_e'(bus.cmd_op);
            r_count <= bus.cmd_rep;
            r_rd    <= bus.cmd_rd;
        end else if (r_state == ST_EXEC) begin
            r_opa <= bus.alu_c;
            if (w_done) begin
                r_rsp_data <= bus.alu_c;
                r_rsp_cout <= bus.alu_cout;
            end else begin
                r_count <= r_count - REP_W'(1);
            end
        end else if (w_rsp_hs) begin
            r_rsp_data <= '0;
            r_rsp_cout <= 1'b0;
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.alu_a     = r_opa;
    assign bus.alu_b     = r_opb;
    assign bus.alu_op    = r_op;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer with a behavioural ALU and command-level reference model.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [15:0] m_reg [4];
    logic [15:0] d;
    logic        co;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {cout, c}
    function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h0: return {1'b0, a} + {1'b0, b};
            4'h1: return {1'b0, a} + {1'b0, ~b} + 17'd1;
            4'h2: return {1'b0, a & b};
            4'h3: return {1'b0, a | b};
            4'h4: return {1'b0, ~(a & b)};
            4'h5: return {1'b0, ~(a | b)};
            4'h6: return {1'b0, a ^ b};
            4'h7: return {1'b0, ~(a ^ b)};
            4'h8: return {1'b0, a};
            4'h9: return {1'b0, ~a};
            4'hA: return {a[0], 1'b0, a[15:1]};
            4'hB: return {a[0], a[15], a[15:1]};
            4'hC: return {a[0], a[0], a[15:1]};
            4'hD: return {a[15], a[14:0], 1'b0};
            4'hE: return {a[15], a[14:0], 1'b0};
            default: return {a[15], a[14:0], a[15]};
        endcase
    endfunction

    always_comb begin
        {bus.alu_cout, bus.alu_c} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    function automatic logic [16:0] ref_cmd(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input int rep);
        logic [16:0] res;
        res = '0;
        for (int i = 0; i <= rep; i++) begin
            res = alu_ref(op, a, b);
            a   = res[15:0];
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble(input logic en);
        bus.cmd_valid  = en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.cmd_op     = 4'($urandom);
        bus.cmd_rd     = 2'($urandom);
        bus.cmd_rs1    = 2'($urandom);
        bus.cmd_rs2    = 2'($urandom);
        bus.cmd_imm_en = 1'($urandom);
        bus.cmd_imm    = 16'($urandom);
        bus.cmd_rep    = 4'($urandom);
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic imm_en, input logic [15:0] imm,
                            input logic [3:0] rep, input int hold, input logic noise,
                            output logic [15:0] o_data, output logic o_cout);
        logic [16:0] exp;
        int n;
        exp = ref_cmd(op, m_reg[rs1], imm_en ? imm : m_reg[rs2], int'(rep));
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        bus.cmd_imm_en = imm_en; bus.cmd_imm = imm; bus.cmd_rep = rep;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        scramble(noise);
        n = 0;
        while (n < 40 && !bus.rsp_valid) begin
            chk("cmd_ready_exec", 32'(bus.cmd_ready), 32'd0);
            bus.rsp_ready = noise ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        bus.rsp_ready = 1'b0;
        chk("latency", 32'(n), 32'(rep) + 32'd1);
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp[15:0]));
        chk("rsp_cout", 32'(bus.rsp_cout), 32'(exp[16]));
        o_data = bus.rsp_data;
        o_cout = bus.rsp_cout;
        for (int h = 0; h < hold; h++) begin
            scramble(noise);
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_data", 32'(bus.rsp_data), 32'(exp[15:0]));
            chk("hold_cout", 32'(bus.rsp_cout), 32'(exp[16]));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("hs_valid_clr", 32'(bus.rsp_valid), 32'd0);
        chk("hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("hs_data_clr", 32'(bus.rsp_data), 32'd0);
        m_reg[rd] = exp[15:0];
    endtask

    initial begin
        reset = 1'b1;
        scramble(1'b0);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(OP_ID));
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // load r1..r3 then reset in the middle of a long command
        send_cmd(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 16'h1111, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 16'h2222, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 16'h3333, 4'd0, 0, 1'b0, d, co);
        @(negedge clk);
        bus.cmd_op = OP_ADD; bus.cmd_rd = 2'd1; bus.cmd_rs1 = 2'd1; bus.cmd_imm_en = 1'b1;
        bus.cmd_imm = 16'h0001; bus.cmd_rep = 4'd5; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_alu_op", 32'(bus.alu_op), 32'(OP_ID));
        chk("midrst_alu_b", 32'(bus.alu_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(OP_OR, 2'(i), 2'(i), 2'd0, 1'b1, 16'h0000, 4'd0, 0, 1'b0, d, co);
            chk("midrst_reg_zero", 32'(d), 32'd0);
        end

        send_cmd(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 16'h00F0, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_LLS, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000, 4'd3, 0, 1'b0, d, co);
        chk("t2_lls4", 32'(d), 32'h0F00);

        send_cmd(OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 16'h5A5A, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 16'hFFFF, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 16'h0001, 4'd0, 0, 1'b0, d, co);
        chk("t3_add_data", 32'(d), 32'h0000);
        chk("t3_add_cout", 32'(co), 32'd1);
        send_cmd(OP_OR, 2'd0, 2'd3, 2'd0, 1'b1, 16'h0000, 4'd0, 5, 1'b1, d, co);
        chk("t3_reg3", 32'(d), 32'h0000);

        send_cmd(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 16'h8001, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_RL, 2'd1, 2'd1, 2'd0, 1'b0, 16'h0000, 4'd0, 0, 1'b0, d, co);
        chk("t5_rl", 32'(d), 32'h0003);
        send_cmd(OP_OR, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0000, 4'd0, 0, 1'b0, d, co);
        chk("t5_b2b_readback", 32'(d), 32'h0003);

        send_cmd(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 16'h1234, 4'd0, 0, 1'b0, d, co);
        send_cmd(OP_RR, 2'd3, 2'd2, 2'd0, 1'b0, 16'h0000, 4'd15, 0, 1'b0, d, co);
        chk("t6_rr16", 32'(d), 32'h1234);

        for (int k = 0; k < 60; k++) begin
            logic [3:0] rep;
            rep = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            send_cmd(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                     16'($urandom), rep, $urandom_range(0, 3), 1'($urandom), d, co);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
